// File: rtl/rr_arbiter_83.sv
// Round-robin arbiter for 8 requesters: rotated 8:3 priority encode, registered grants.
// Optional hold-limit revocation is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_83 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     r_state;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_id;
  logic       r_gnt_valid;
  logic       r_timeout;
  logic [2:0] r_last_ptr;

  logic [7:0] w_arb_req;
  logic       w_found;
  logic [2:0] w_win;
  logic       w_revoke;
  logic       w_hold;

  if ((1 << CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("rr_arbiter_83: CNT_W too narrow for MAX_HOLD");
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_hold_cnt;

  // Revoke only when someone else is actually waiting.
  assign w_revoke = (r_state == StGrant) && req[r_gnt_id] &&
                    (r_hold_cnt == CNT_W'(MAX_HOLD - 1)) && (|(req & ~r_gnt));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (!w_hold) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != '1) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end
`else
  assign w_revoke = 1'b0;
`endif

  assign w_hold    = (r_state == StGrant) && req[r_gnt_id] && !w_revoke;
  assign w_arb_req = w_revoke ? (req & ~r_gnt) : req;
  assign w_found   = |w_arb_req;

  // Walk downward so the first set bit after last_ptr (mod 8) is the final assignment.
  always_comb begin
    w_win = r_last_ptr;
    for (int i = 8; i >= 1; i--) begin
      if (w_arb_req[r_last_ptr + 3'(i)]) begin
        w_win = r_last_ptr + 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_last_ptr  <= 3'd7;
    end else begin
      r_timeout <= 1'b0;
      if (!w_hold) begin
        if (w_found) begin
          r_state     <= StGrant;
          r_gnt       <= 8'b1 << w_win;
          r_gnt_id    <= w_win;
          r_gnt_valid <= 1'b1;
          r_last_ptr  <= w_win;
          r_timeout   <= w_revoke;
        end else begin
          r_state     <= StIdle;
          r_gnt       <= '0;
          r_gnt_id    <= '0;
          r_gnt_valid <= 1'b0;
        end
      end
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_83.sv
// Directed bench for rr_arbiter_83; hold-limit scenario runs when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter_83;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_arbiter_83 #(
    .MAX_HOLD(4),
    .CNT_W   (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_id,
                         input logic e_valid, input logic e_to);
    chk({tag, ".gnt"}, gnt, e_gnt);
    chk({tag, ".gnt_id"}, {5'd0, gnt_id}, {5'd0, e_id});
    chk({tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, e_valid});
    chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, e_to});
  endtask

  initial begin
    logic [7:0] r;
    rst = 1'b1;
    req = 8'h00;
    step();
    step();
    chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // Single request and release.
    rst = 1'b0;
    req = 8'h01;
    step();
    chk_all("single_gnt", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk_all("single_rel", 8'h00, 3'd0, 1'b0, 1'b0);

    // Full sweep from a fresh pointer: owners drop one cycle after grant.
    rst = 1'b1;
    step();
    rst = 1'b0;
    r   = 8'hFF;
    req = r;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all($sformatf("sweep%0d", i), 8'h01 << i, 3'(i), 1'b1, 1'b0);
      r   = r & ~(8'h01 << i);
      req = r;
    end
    step();
    chk_all("sweep_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // Wraparound from last_ptr=6.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'h40;
    step();
    chk_all("wrap_pre", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'h00;
    step();
    req = 8'h81;
    step();
    chk_all("wrap_7", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h01;
    step();
    chk_all("wrap_0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk_all("wrap_idle", 8'h00, 3'd0, 1'b0, 1'b0);

`ifndef ARB_TIMEOUT_EN
    // last_ptr=0: owner 3 keeps the grant past any hold limit.
    req = 8'h08;
    step();
    chk_all("hold_gnt", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_all($sformatf("hold%0d", i), 8'h08, 3'd3, 1'b1, 1'b0);
    end
    req = 8'h34;
    step();
    chk_all("hold_next", 8'h10, 3'd4, 1'b1, 1'b0);
    req = 8'h00;
    step();
`else
    // MAX_HOLD=4: req 0 and 2 held from reset alternate every 4 cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'h05;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all($sformatf("to_a%0d", i), 8'h01, 3'd0, 1'b1, 1'b0);
    end
    step();
    chk_all("to_b0", 8'h04, 3'd2, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_all($sformatf("to_b%0d", i), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    step();
    chk_all("to_c0", 8'h01, 3'd0, 1'b1, 1'b1);
    // Lone owner: saturates, no pulse.
    req = 8'h01;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all($sformatf("to_lone%0d", i), 8'h01, 3'd0, 1'b1, 1'b0);
    end
    req = 8'h00;
    step();
`endif

    // Reset mid-grant, then pointer restarts at 7.
    req = 8'h10;
    step();
    chk_all("rst_pre", 8'h10, 3'd4, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk_all("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 8'h30;
    step();
    chk_all("rst_post", 8'h10, 3'd4, 1'b1, 1'b0);
    req = 8'h00;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
